// File: rtl/debounce_multi_ch.sv
// debounce_multi_ch: N-channel symmetric debouncer with registered level and
// one-clock rise/fall pulses. Each channel owns a 4-state FSM and a saturating
// sample counter. All channels share one sample strobe (ce).
// Optional build macro DEBOUNCE_SYNC_EN adds a 2-flop synchronizer per channel.
// The synchronizer runs every clk and adds 2 clk of latency.

module debounce_ch #(
  parameter int N_TICS = 3,
  parameter int CW     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic s,
  output logic y,
  output logic rise,
  output logic fall
);
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_e;

  localparam logic [CW-1:0] LAST = CW'(N_TICS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          y_q, y_d, rise_q, rise_d, fall_q, fall_d;

  // next-state: only evaluated on ce; pulses default low every clk
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (ce) begin
      case (state_q)
        LOW: if (s) begin
          state_d = RISE_WAIT;
          cnt_d   = '0;
        end
        RISE_WAIT: begin
          if (!s) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = HIGH;
            cnt_d   = '0;
            y_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HIGH: if (!s) begin
          state_d = FALL_WAIT;
          cnt_d   = '0;
        end
        FALL_WAIT: begin
          if (s) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = LOW;
            cnt_d   = '0;
            y_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
          y_d     = 1'b0;
        end
      endcase
    end
  end

  // state, counter and registered outputs; reset aborts any count in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign y    = y_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

module debounce_multi_ch #(
  parameter int N_CH   = 4,
  parameter int N_TICS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [N_CH-1:0] x,
  output logic [N_CH-1:0] y,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);
  localparam int CW = $clog2(N_TICS + 1);

  logic [N_CH-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
  logic [N_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  // synchronizer shift: advances every clk regardless of ce
  always_comb begin
    sync1_d = x;
    sync2_d = sync1_q;
  end

  // synchronizer flops clear with the rest of the block
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = x;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(.N_TICS(N_TICS), .CW(CW)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .ce   (ce),
      .s    (s[i]),
      .y    (y[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end
endmodule

// File: tb/tb_debounce_multi_ch.sv
// Directed bench for debounce_multi_ch: 4 channels with N_TICS=3, plus a
// 1-channel N_TICS=1 instance fed from x[0]. Latencies add 2 clk when the
// synchronizer build macro is defined.

module tb_debounce_multi_ch;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int NT = 3;

  logic       clk = 1'b0;
  logic       rst, ce;
  logic [3:0] x, y, rise, fall;
  logic [0:0] y1, rise1, fall1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_multi_ch #(.N_CH(4), .N_TICS(NT)) dut (
    .clk(clk), .rst(rst), .ce(ce), .x(x), .y(y), .rise(rise), .fall(fall)
  );

  debounce_multi_ch #(.N_CH(1), .N_TICS(1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .x(x[0:0]), .y(y1), .rise(rise1), .fall(fall1)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // advance one edge, settle, and check pulse exclusivity on every channel
  task automatic tick();
    @(posedge clk);
    #1;
    chk("rise_and_fall_exclusive", rise & fall, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; x = 4'b1111;
    // reset with inputs high
    tick();
    chk("rst1_y", y, 4'b0000); chk("rst1_rise", rise, 4'b0000); chk("rst1_fall", fall, 4'b0000);
    chk("rst1_y1", {3'b0, y1}, 4'b0000);
    tick();
    chk("rst2_y", y, 4'b0000); chk("rst2_rise", rise, 4'b0000); chk("rst2_fall", fall, 4'b0000);
    rst = 1'b0;
    repeat (NT + SL) begin
      tick();
      chk("post_rst_y_low", y, 4'b0000);
      chk("post_rst_rise_low", rise, 4'b0000);
    end
    tick();
    chk("post_rst_rise_y", y, 4'b1111); chk("post_rst_rise", rise, 4'b1111);

    // drop all channels
    x = 4'b0000;
    repeat (NT + SL) tick();
    chk("all_fall_y_hold", y, 4'b1111);
    tick();
    chk("all_fall_y", y, 4'b0000); chk("all_fall_pulse", fall, 4'b1111);
    tick();
    chk("all_fall_pulse_clear", fall, 4'b0000);

    // clean press on channel 0 (also N_TICS=1 instance)
    x = 4'b0001;
    tick();
    chk("press_e0_y", y, 4'b0000); chk("press_e0_y1", {3'b0, y1}, 4'b0000);
    repeat (SL) tick();
    tick();
    chk("nt1_y1", {3'b0, y1}, 4'b0001); chk("nt1_rise1", {3'b0, rise1}, 4'b0001);
    chk("press_e1_y", y, 4'b0000);
    tick();
    chk("nt1_rise1_clear", {3'b0, rise1}, 4'b0000); chk("press_e2_y", y, 4'b0000);
    tick();
    chk("press_e3_y", y, 4'b0001); chk("press_e3_rise", rise, 4'b0001);
    tick();
    chk("press_e4_rise", rise, 4'b0000); chk("press_e4_y", y, 4'b0001);

    // 2-clk high glitch on channel 1
    x = 4'b0011; tick(); tick();
    x = 4'b0001;
    repeat (8) begin
      tick();
      chk("glitch_rise_y", y, 4'b0001); chk("glitch_rise_pulse", rise, 4'b0000);
    end

    // raise channel 1, then 2-clk low glitch
    x = 4'b0011;
    repeat (NT + SL + 1) tick();
    chk("ch1_high_y", y, 4'b0011);
    x = 4'b0001; tick(); tick();
    x = 4'b0011;
    repeat (8) begin
      tick();
      chk("glitch_fall_y", y, 4'b0011); chk("glitch_fall_pulse", fall, 4'b0000);
    end

    // prescaled strobe: ce once every 4 clk, channel 2 held high
    x = 4'b0111; ce = 1'b0;
    repeat (3) tick();
    chk("pre_ce_hold_y", y, 4'b0011);
    for (int k = 1; k <= 4; k++) begin
      ce = 1'b1; tick(); ce = 1'b0;
      chk("ce_edge_y", y, (k == 4) ? 4'b0111 : 4'b0011);
      chk("ce_edge_rise", rise, (k == 4) ? 4'b0100 : 4'b0000);
      repeat (3) begin
        tick();
        chk("ce_off_y", y, (k == 4) ? 4'b0111 : 4'b0011);
        chk("ce_off_rise", rise, 4'b0000);
      end
    end
    ce = 1'b1;

    // channel 0 falls and channel 3 rises together
    x = 4'b1110;
    repeat (NT + SL) begin
      tick();
      chk("simul_wait_rise", rise, 4'b0000); chk("simul_wait_fall", fall, 4'b0000);
    end
    tick();
    chk("simul_y", y, 4'b1110); chk("simul_rise", rise, 4'b1000); chk("simul_fall", fall, 4'b0001);

    // channel 1 low, then reset mid-count
    x = 4'b1100;
    repeat (NT + SL + 1) tick();
    chk("ch1_low_y", y, 4'b1100);
    x = 4'b1110;
    repeat (SL + 3) tick();
    chk("midcnt_y", y, 4'b1100);
    rst = 1'b1; tick();
    chk("midcnt_rst_y", y, 4'b0000); chk("midcnt_rst_rise", rise, 4'b0000);
    chk("midcnt_rst_fall", fall, 4'b0000);
    rst = 1'b0;
    repeat (NT + SL) begin
      tick();
      chk("recount_y", y, 4'b0000); chk("recount_rise", rise, 4'b0000);
    end
    tick();
    chk("recount_done_y", y, 4'b1110); chk("recount_done_rise", rise, 4'b1110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
